// File: rtl/lfsr_pkg.sv
// Shared definitions for the 23-bit LFSR pattern source and its checker.
// Both ends import this package so the polynomial (x^23 + x^18 + 1) and
// the checker state encodings are defined in exactly one place.
//   LFSR_LEN  : history / generator register length
//   TAP_HI/LO : feedback taps (h[0] is the newest bit)
//   lfsr_state_e : checker states, encoded for direct LED display
package lfsr_pkg;

  localparam int LFSR_LEN = 23;
  localparam int TAP_HI   = 22;
  localparam int TAP_LO   = 17;

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    VERIFY = 2'b01,
    LOCKED = 2'b10
  } lfsr_state_e;

  // Next bit of the sequence given the last LFSR_LEN bits (h[0] newest).
  function automatic logic lfsr_predict(input logic [LFSR_LEN-1:0] h);
    return h[TAP_HI] ^ h[TAP_LO];
  endfunction

endpackage

// File: rtl/lfsr_err_window.sv
// Windowed error counter for the LFSR checker.
// Counts stepped bits modulo WINDOW and errors inside the current window.
// limit_hit is a same-cycle strobe: high when the current stepped bit is an
// error and it brings the window's error total to ERR_LIMIT.
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset
//   clear     : synchronous clear of both counters (used on lock entry)
//   step      : one bit is being judged this cycle
//   err       : that bit was mispredicted (only meaningful with step)
//   limit_hit : error limit reached by this bit
module lfsr_err_window #(
  parameter int WINDOW    = 1024,
  parameter int ERR_LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic step,
  input  logic err,
  output logic limit_hit
);

  localparam int BW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int EW = $clog2(ERR_LIMIT + 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(WINDOW - 1);
  localparam logic [EW-1:0] ERR_MAX   = EW'(ERR_LIMIT);

  logic [BW-1:0] win_bits;
  logic [EW-1:0] win_err;
  logic [EW-1:0] win_err_inc;

  // The current bit's error is counted before the limit compare, so an error
  // on the last bit of a window still belongs to the closing window.
  assign win_err_inc = win_err + EW'(err);
  assign limit_hit   = step && err && (win_err_inc == ERR_MAX);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      win_bits <= '0;
      win_err  <= '0;
    end else if (step) begin
      if (win_bits == BITS_LAST) begin
        win_bits <= '0;
        win_err  <= '0;
      end else begin
        win_bits <= win_bits + BW'(1);
        win_err  <= win_err_inc;
      end
    end
  end

endmodule

// File: rtl/lfsr_23b_checker.sv
// Receive-side checker for the 23-bit LFSR pattern (x^23 + x^18 + 1).
// Self-synchronises to a serial PRBS stream, declares lock after
// LOCK_COUNT consecutive correct predictions, then counts bit errors and
// drops back to HUNT when ERR_LIMIT errors land in one WINDOW of bits.
// Input handshake: bit_in is consumed on every rising CCLK edge where
// bit_valid is high; there is no backpressure and any duty cycle is accepted.
// Cycles with bit_valid low change nothing except clr_err and the pulses.
//   CCLK      : system clock, rising edge
//   reset     : synchronous active-high reset
//   bit_in    : received serial bit
//   bit_valid : bit_in qualifier
//   clr_err   : synchronous clear of err_count (wins over a same-cycle error)
//   locked    : high while in LOCKED
//   bit_err   : one-cycle pulse per mispredicted bit while LOCKED
//   sync_loss : one-cycle pulse on LOCKED -> HUNT
//   err_count : saturating error count, survives loss of lock
//   state_out : current state encoding (HUNT=00, VERIFY=01, LOCKED=10)
module lfsr_23b_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT = 64,
  parameter int ERR_LIMIT  = 8,
  parameter int WINDOW     = 1024,
  parameter int ERR_W      = 16
) (
  input  logic             CCLK,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr_err,
  output logic             locked,
  output logic             bit_err,
  output logic             sync_loss,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state_out
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [4:0]    FILL_LAST  = 5'(LFSR_LEN - 1);

  lfsr_state_e          state, state_nx;
  logic [LFSR_LEN-1:0]  hist;
  logic [4:0]           fill_cnt;
  logic [MW-1:0]        match_cnt;
  logic                 match;
  logic                 limit_hit;
  logic                 win_step;
  logic                 win_clear;

  logic                 locked_d, bit_err_d, sync_loss_d;
  logic [ERR_W-1:0]     err_count_d;

  // An all-zero history is the LFSR's lock-up state; it predicts zero
  // forever, so it is never accepted as a match.
  assign match     = (bit_in == lfsr_predict(hist)) && (hist != '0);
  assign win_step  = bit_valid && (state == LOCKED);
  assign win_clear = bit_valid && (state == VERIFY) && (state_nx == LOCKED);

  lfsr_err_window #(
    .WINDOW    (WINDOW),
    .ERR_LIMIT (ERR_LIMIT)
  ) u_err_window (
    .clk       (CCLK),
    .reset     (reset),
    .clear     (win_clear),
    .step      (win_step),
    .err       (!match),
    .limit_hit (limit_hit)
  );

  // State register
  always_ff @(posedge CCLK) begin
    if (reset) state <= HUNT;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    if (bit_valid) begin
      case (state)
        HUNT:    if (fill_cnt == FILL_LAST)            state_nx = VERIFY;
        VERIFY:  if (match && match_cnt == MATCH_LAST) state_nx = LOCKED;
        LOCKED:  if (limit_hit)                        state_nx = HUNT;
        default:                                       state_nx = HUNT;
      endcase
    end
  end

  // History and sync counters. Counters are held at zero outside their own
  // state, so re-entering HUNT or VERIFY always starts them from zero while
  // the history keeps running across every state.
  always_ff @(posedge CCLK) begin
    if (reset) begin
      hist      <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
    end else if (bit_valid) begin
      hist      <= {hist[LFSR_LEN-2:0], bit_in};
      fill_cnt  <= (state == HUNT && state_nx == HUNT) ? fill_cnt + 5'd1 : 5'd0;
      match_cnt <= (state == VERIFY && state_nx == VERIFY && match)
                   ? match_cnt + MW'(1) : '0;
    end
  end

  // Output logic: next values of the registered status outputs
  always_comb begin
    locked_d    = (state_nx == LOCKED);
    bit_err_d   = win_step && !match;
    sync_loss_d = (state == LOCKED) && (state_nx == HUNT);
    err_count_d = err_count;
    if (clr_err)
      err_count_d = '0;
    else if (bit_err_d && err_count != '1)
      err_count_d = err_count + ERR_W'(1);
  end

  always_ff @(posedge CCLK) begin
    if (reset) begin
      locked    <= 1'b0;
      bit_err   <= 1'b0;
      sync_loss <= 1'b0;
      err_count <= '0;
    end else begin
      locked    <= locked_d;
      bit_err   <= bit_err_d;
      sync_loss <= sync_loss_d;
      err_count <= err_count_d;
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_lfsr_23b_checker.sv
// Bench for lfsr_23b_checker (instantiated with ERR_W=4 so saturation is
// reachable). Each scenario is a table of hand-derived events in valid-bit
// numbering: state transitions, flipped bits, expected bit_err bits, the
// sync_loss bit and a clr_err bit. The driver pushes the expected output
// tuple for every valid bit; the monitor pops it one cycle later.
module tb_lfsr_23b_checker;
  import lfsr_pkg::*;

  localparam int EW = 4;

  logic          CCLK = 1'b0;
  logic          reset, bit_in, bit_valid, clr_err;
  logic          locked, bit_err, sync_loss;
  logic [EW-1:0] err_count;
  logic [1:0]    state_out;

  // Tuple layout: {state[8:7], locked[6], bit_err[5], sync_loss[4], err_count[3:0]}
  logic [8:0] exp_q[$];
  logic [8:0] last_exp;

  int n_cmp  = 0;
  int n_fail = 0;

  // Scenario tables
  int          tr_bit[6];
  logic [1:0]  tr_st[6];
  int          n_tr;
  int          flip_bit[8];
  int          n_flip;
  int          err_bit[24];
  int          n_err;
  int          loss_bit;
  int          clr_bit;
  logic        zero_mode;

  logic [22:0] gen;
  int          bit_no;
  logic [EW-1:0] exp_cnt;

  lfsr_23b_checker #(
    .LOCK_COUNT (64),
    .ERR_LIMIT  (8),
    .WINDOW     (1024),
    .ERR_W      (EW)
  ) dut (
    .CCLK      (CCLK),
    .reset     (reset),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clr_err   (clr_err),
    .locked    (locked),
    .bit_err   (bit_err),
    .sync_loss (sync_loss),
    .err_count (err_count),
    .state_out (state_out)
  );

  // Clock
  always #5 CCLK = ~CCLK;

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got st=%b lk=%b err=%b loss=%b cnt=%0d required st=%b lk=%b err=%b loss=%b cnt=%0d",
               name, $time, got[8:7], got[6], got[5], got[4], got[3:0],
               exp[8:7], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  function automatic logic [1:0] exp_state_at(input int n);
    logic [1:0] st = HUNT;
    for (int i = 0; i < n_tr; i++)
      if (tr_bit[i] <= n) st = tr_st[i];
    return st;
  endfunction

  function automatic logic is_flip(input int n);
    for (int i = 0; i < n_flip; i++)
      if (flip_bit[i] == n) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic is_err(input int n);
    for (int i = 0; i < n_err; i++)
      if (err_bit[i] == n) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_tr(input int b, input logic [1:0] st);
    tr_bit[n_tr] = b;
    tr_st[n_tr]  = st;
    n_tr++;
  endtask

  // A flipped bit is mispredicted itself and poisons the taps 18 and 23
  // bits later.
  task automatic add_flip(input int b, input logic with_errs);
    flip_bit[n_flip] = b;
    n_flip++;
    if (with_errs) begin
      err_bit[n_err] = b;      n_err++;
      err_bit[n_err] = b + 18; n_err++;
      err_bit[n_err] = b + 23; n_err++;
    end
  endtask

  task automatic add_err(input int b);
    err_bit[n_err] = b;
    n_err++;
  endtask

  // Driver: one valid bit, preceded by `idle` invalid cycles carrying junk.
  task automatic send_bit(input int idle);
    logic       b;
    logic       e_err;
    logic [1:0] st;
    for (int i = 0; i < idle; i++) begin
      @(negedge CCLK);
      bit_valid = 1'b0;
      clr_err   = 1'b0;
      bit_in    = 1'($urandom_range(0, 1));
    end
    @(negedge CCLK);
    bit_no++;
    b   = zero_mode ? 1'b0 : gen[22];
    gen = {gen[21:0], gen[22] ^ gen[17]};
    if (is_flip(bit_no)) b = ~b;
    bit_in    = b;
    bit_valid = 1'b1;
    clr_err   = (bit_no == clr_bit);
    e_err     = is_err(bit_no);
    if (bit_no == clr_bit)          exp_cnt = '0;
    else if (e_err && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    st = exp_state_at(bit_no);
    exp_q.push_back({st, (st == LOCKED), e_err, (bit_no == loss_bit), exp_cnt});
  endtask

  task automatic run_bits(input int n, input int idle);
    for (int i = 0; i < n; i++) send_bit(idle);
    @(negedge CCLK);
    bit_valid = 1'b0;
    clr_err   = 1'b0;
    repeat (3) @(negedge CCLK);
  endtask

  // Reset for one edge (optionally with a valid bit present) and check
  // that every output is zero right after that edge.
  task automatic do_reset(input logic with_valid);
    @(negedge CCLK);
    reset     = 1'b1;
    bit_valid = with_valid;
    bit_in    = with_valid;
    clr_err   = 1'b0;
    @(negedge CCLK);
    check("reset", {state_out, locked, bit_err, sync_loss, err_count}, 9'h000);
    reset     = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    n_tr = 0; n_flip = 0; n_err = 0;
    loss_bit  = -1;
    clr_bit   = -1;
    zero_mode = 1'b0;
    gen       = 23'h000001;
    bit_no    = 0;
    exp_cnt   = '0;
  endtask

  // Monitor / scoreboard
  initial begin
    logic       v, r;
    logic [8:0] got, e;
    last_exp = '0;
    forever begin
      @(posedge CCLK);
      v = bit_valid;
      r = reset;
      @(negedge CCLK);
      got = {state_out, locked, bit_err, sync_loss, err_count};
      if (r) begin
        last_exp = '0;
      end else if (v) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL scoreboard: valid bit with no expected entry, got %h", got);
        end else begin
          e = exp_q.pop_front();
          check("bit", got, e);
          last_exp = e;
        end
      end else begin
        // No bit consumed: pulses drop, everything else holds.
        last_exp = {last_exp[8:6], 2'b00, last_exp[3:0]};
        check("idle", got, last_exp);
      end
    end
  end

  // Stimulus
  initial begin
    reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; clr_err = 1'b0;

    // Clean lock, then a single channel flip at bit 200.
    do_reset(1'b0);
    add_tr(23, VERIFY);
    add_tr(87, LOCKED);
    add_flip(200, 1'b1);
    run_bits(300, 0);

    // Sync loss: flips every 30 bits from 200. The 8th error in the window
    // lands at 278; refill ends at 301; flips up to 410 keep poisoning
    // VERIFY until 433, so the re-lock comes 64 clean bits later at 497.
    do_reset(1'b0);
    add_tr(23, VERIFY);
    add_tr(87, LOCKED);
    add_tr(278, HUNT);
    add_tr(301, VERIFY);
    add_tr(497, LOCKED);
    for (int k = 0; k < 8; k++) add_flip(200 + 30 * k, 1'b0);
    add_err(200); add_err(218); add_err(223); add_err(230);
    add_err(248); add_err(253); add_err(260); add_err(278);
    loss_bit = 278;
    run_bits(560, 0);

    // All-zero stream never locks.
    do_reset(1'b0);
    zero_mode = 1'b1;
    add_tr(23, VERIFY);
    run_bits(500, 0);

    // Sparse valid (1 in 5) with junk on invalid cycles: same bit timing.
    do_reset(1'b0);
    add_tr(23, VERIFY);
    add_tr(87, LOCKED);
    run_bits(150, 4);

    // Saturation across windows (two flips per 1024-bit window), then a
    // clr_err coinciding with the error at 3300, then a mid-run reset.
    do_reset(1'b0);
    add_tr(23, VERIFY);
    add_tr(87, LOCKED);
    add_flip(200, 1'b1);  add_flip(400, 1'b1);
    add_flip(1200, 1'b1); add_flip(1400, 1'b1);
    add_flip(2200, 1'b1); add_flip(2400, 1'b1);
    add_flip(3200, 1'b1); add_flip(3300, 1'b1);
    clr_bit = 3300;
    for (int i = 0; i < 3330; i++) send_bit(0);
    do_reset(1'b1);

    repeat (3) @(negedge CCLK);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_23b_checker.md
Name: lfsr_23b_checker

Overview:
- Receive-side counterpart of the team's 23-bit LFSR pattern source.
- Accepts a serial PRBS bit stream (x^23 + x^18 + 1) with a valid strobe and self-synchronises to it. Declares lock, then counts bit errors and detects loss of sync.
- Sits on the board clock, after whatever serialiser or clock-divided source carries the LFSR output. Status is registered for direct LED display.

Parameters:
- LOCK_COUNT, 64: consecutive correct predictions required in VERIFY to enter LOCKED.
- ERR_LIMIT, 8: errors within one window that force loss of sync (must be > 3).
- WINDOW, 1024: window length in valid bits for the error-limit check.
- ERR_W, 16: width of the saturating error counter.

Ports:
- CCLK  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- bit_in  in  1  received serial data bit.
- bit_valid  in  1  bit_in is sampled on cycles where this is high; any duty cycle allowed.
- clr_err  in  1  synchronous clear of err_count.
- locked  out  1  high while in LOCKED.
- bit_err  out  1  one-cycle pulse per mispredicted bit while LOCKED.
- sync_loss  out  1  one-cycle pulse on the LOCKED->HUNT transition.
- err_count  out  ERR_W  saturating count of bit_err pulses.
- state_out  out  2  current state encoding, for LEDs.

Behaviour:
- Reset: all registers 0; state HUNT; locked=0, bit_err=0, sync_loss=0, err_count=0, state_out=00.
- History register h[22:0] with h[0] = newest bit. On every valid bit, in every state, h <= {h[21:0], bit_in}.
- Prediction is pred = h[22] ^ h[17], computed before the shift. A bit matches when bit_in == pred.
- Nothing changes on cycles with bit_valid=0.
- All outputs are registered and reflect a valid bit one cycle after it is sampled.
- State encoding: HUNT=00, VERIFY=01, LOCKED=10.
- HUNT:
  - A 5-bit fill counter increments per valid bit.
  - When the 23rd bit is shifted in, go to VERIFY with match_cnt=0.
- VERIFY:
  - Match: match_cnt++.
  - Mismatch: match_cnt=0, stay in VERIFY. History self-resynchronises.
  - All-zero history (h==0 before shift): treated as mismatch, so a zero stream never locks.
  - When match_cnt reaches LOCK_COUNT: go to LOCKED and clear the window counters.
- LOCKED:
  - Mismatch or all-zero history: bit_err pulse, err_count+1 saturating at 2^ERR_W-1, win_err+1.
  - win_bits counts valid bits modulo WINDOW.
  - If win_err reaches ERR_LIMIT, including the current bit: go to HUNT, reset fill and match counters, pulse sync_loss, locked=0 next cycle. History is kept.
  - At the window wrap (win_bits == WINDOW-1), win_err clears. An error on that same last bit is counted into the closing window first; the limit check uses the incremented value.
- A single channel bit flip yields exactly 3 bit_err pulses, at stream offsets +0, +18 and +23. This is required behaviour, not a defect.
- clr_err: err_count <= 0. If clr_err coincides with an error, clear wins and err_count = 0.
- err_count survives loss of lock; only reset or clr_err clears it.
- reset asserted mid-stream: return to reset state on the next edge regardless of bit_valid.

Decomposition:
- Shared package lfsr_pkg:
  - LFSR_LEN=23, TAP_HI=22, TAP_LO=17.
  - State encodings HUNT/VERIFY/LOCKED.
  - Shared with the generator so both ends use one polynomial definition.
- One sub-module is natural: lfsr_err_window. It holds win_bits, win_err and limit compare, takes the error and valid strobes, and outputs a limit_hit strobe.
- Prediction, history and FSM stay in the top module.

Test Plan:
- Clean lock: reset, then a model stream (x^23+x^18+1, seed 23'h000001) with bit_valid continuously high -> state_out=01 after bit 23; locked rises one cycle after bit 87; no bit_err; err_count=0.
- Single flip: after lock, invert bit 200 -> exactly 3 bit_err pulses, for bits 200, 218 and 223; err_count=3; locked stays 1.
- Sync loss: after lock, invert 8 bits spaced 30 apart within one window -> sync_loss pulse, state_out=00, err_count counts every mispredicted bit to that point. Then clean stream -> re-lock after 23+64 further bits.
- All-zero stream: 500 zero bits after reset -> never leaves VERIFY; locked=0.
- Sparse valid: bit_valid high 1 cycle in 5, with bit_in toggled randomly on invalid cycles -> identical lock timing in valid-bit units; invalid-cycle data has no effect.
- Clear/saturate: with ERR_W=4, force 20 errors spread across windows -> err_count holds 15. clr_err coincident with an error -> err_count=0. Mid-run reset -> all outputs 0 the next cycle.
